// File: rtl/lockstep_checker.sv
// Dual-core lockstep comparator: registers both cores' bus bundles, compares them a cycle later
// and tracks divergences through an IDLE/RUN/ERR/FATAL FSM with a saturating counter.
// states: IDLE=0 not comparing | RUN=1 comparing, clean | ERR=2 below threshold | FATAL=3 sticky
module lockstep_checker #(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             instr_req_cls1_i,
  input  logic [31:0]      instr_addr_cls1_i,
  input  logic             data_req_cls1_i,
  input  logic             data_we_cls1_i,
  input  logic [3:0]       data_be_cls1_i,
  input  logic [31:0]      data_addr_cls1_i,
  input  logic [31:0]      data_wdata_cls1_i,
  input  logic             instr_req_cls2_i,
  input  logic [31:0]      instr_addr_cls2_i,
  input  logic             data_req_cls2_i,
  input  logic             data_we_cls2_i,
  input  logic [3:0]       data_be_cls2_i,
  input  logic [31:0]      data_addr_cls2_i,
  input  logic [31:0]      data_wdata_cls2_i,
  output logic             mismatch_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [4:0]       err_vec_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ERR   = 2'd2,
    S_FATAL = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_s1_en;
  logic        r_ir1, r_ir2;
  logic [31:0] r_ia1, r_ia2;
  logic        r_dr1, r_dr2;
  logic        r_we1, r_we2;
  logic [3:0]  r_be1, r_be2;
  logic [31:0] r_da1, r_da2;
  logic [31:0] r_wd1, r_wd2;

  logic             r_mismatch;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_vec;

  logic [4:0]       w_vec;
  logic             w_cnt_div;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      w_cnt_inc32;
  logic             w_thresh_hit;

  // Stage 1: capture both bundles and enable; enable low naturally flushes the valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_en <= 1'b0;
      r_ir1   <= 1'b0;
      r_ir2   <= 1'b0;
      r_ia1   <= '0;
      r_ia2   <= '0;
      r_dr1   <= 1'b0;
      r_dr2   <= 1'b0;
      r_we1   <= 1'b0;
      r_we2   <= 1'b0;
      r_be1   <= '0;
      r_be2   <= '0;
      r_da1   <= '0;
      r_da2   <= '0;
      r_wd1   <= '0;
      r_wd2   <= '0;
    end else begin
      r_s1_en <= enable_i;
      r_ir1   <= instr_req_cls1_i;
      r_ir2   <= instr_req_cls2_i;
      r_ia1   <= instr_addr_cls1_i;
      r_ia2   <= instr_addr_cls2_i;
      r_dr1   <= data_req_cls1_i;
      r_dr2   <= data_req_cls2_i;
      r_we1   <= data_we_cls1_i;
      r_we2   <= data_we_cls2_i;
      r_be1   <= data_be_cls1_i;
      r_be2   <= data_be_cls2_i;
      r_da1   <= data_addr_cls1_i;
      r_da2   <= data_addr_cls2_i;
      r_wd1   <= data_wdata_cls1_i;
      r_wd2   <= data_wdata_cls2_i;
    end
  end

  always_comb begin
    w_vec    = '0;
    w_vec[0] = (r_ir1 != r_ir2);
    w_vec[1] = r_ir1 && r_ir2 && (r_ia1 != r_ia2);
    w_vec[2] = (r_dr1 != r_dr2);
    w_vec[3] = r_dr1 && r_dr2 && (r_da1 != r_da2);
    w_vec[4] = r_dr1 && r_dr2 &&
               ((r_we1 != r_we2) || (r_we1 && r_we2 && ((r_be1 != r_be2) || (r_wd1 != r_wd2))));
  end

  assign w_cnt_div    = r_s1_en && (|w_vec);
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_cnt_inc32  = 32'(w_cnt_inc);
  assign w_thresh_hit = (w_cnt_inc32 >= THRESH);

  // Stage 2: registered compare result; clear discards a same-cycle divergence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
      r_vec      <= '0;
    end else if (clear_i) begin
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
      r_vec      <= '0;
    end else begin
      r_mismatch <= w_cnt_div;
      if (w_cnt_div) begin
        r_cnt <= w_cnt_inc;
        r_vec <= w_vec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = enable_i ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (enable_i) w_state_nxt = S_RUN;
        S_RUN, S_ERR: begin
          if (w_cnt_div && w_thresh_hit) w_state_nxt = S_FATAL;
          else if (!enable_i)            w_state_nxt = S_IDLE;
          else if (w_cnt_div)            w_state_nxt = S_ERR;
        end
        S_FATAL: w_state_nxt = S_FATAL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign mismatch_o  = r_mismatch;
  assign fatal_o     = (r_state == S_FATAL);
  assign err_count_o = r_cnt;
  assign err_vec_o   = r_vec;
  assign state_o     = r_state;

endmodule
